// File: rtl/xbar2_arbiter.sv
// 2x2 crossbar with registered outputs, round-robin conflict arbitration
// and a saturating conflict counter.
module xbar2_arbiter #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in0_valid,
   input  logic          in0_dest,
   input  logic [DW-1:0] in0_data,
   output logic          in0_ready,
   input  logic          in1_valid,
   input  logic          in1_dest,
   input  logic [DW-1:0] in1_data,
   output logic          in1_ready,
   output logic          out0_valid,
   input  logic          out0_ready,
   output logic [DW-1:0] out0_data,
   output logic          out0_src,
   output logic          out1_valid,
   input  logic          out1_ready,
   output logic [DW-1:0] out1_data,
   output logic          out1_src,
   output logic          sel,
   output logic [7:0]    conflict_cnt
);

   logic          out0_valid_q, out0_valid_d;
   logic [DW-1:0] out0_data_q, out0_data_d;
   logic          out0_src_q, out0_src_d;
   logic          out1_valid_q, out1_valid_d;
   logic [DW-1:0] out1_data_q, out1_data_d;
   logic          out1_src_q, out1_src_d;
   logic          sel_q, sel_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          rr_q, rr_d;

   logic [1:0] free;
   logic       conflict;
   logic       grant0, grant1;
   logic       g0_to0, g0_to1, g1_to0, g1_to1;

   always_comb begin
      free = {!out1_valid_q || out1_ready, !out0_valid_q || out0_ready};
      conflict = in0_valid && in1_valid && (in0_dest == in1_dest)
                 && free[in0_dest];
      // Gated by rst so no beat is accepted while the outputs are cleared
      grant0 = !rst && in0_valid && free[in0_dest] && (!conflict || !rr_q);
      grant1 = !rst && in1_valid && free[in1_dest] && (!conflict || rr_q);
      g0_to0 = grant0 && !in0_dest;
      g0_to1 = grant0 && in0_dest;
      g1_to0 = grant1 && !in1_dest;
      g1_to1 = grant1 && in1_dest;
   end

   always_comb begin
      out0_valid_d = out0_valid_q;
      out0_data_d  = out0_data_q;
      out0_src_d   = out0_src_q;
      out1_valid_d = out1_valid_q;
      out1_data_d  = out1_data_q;
      out1_src_d   = out1_src_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      rr_d         = rr_q;

      if (g0_to0) begin
         out0_valid_d = 1'b1;
         out0_data_d  = in0_data;
         out0_src_d   = 1'b0;
      end else if (g1_to0) begin
         out0_valid_d = 1'b1;
         out0_data_d  = in1_data;
         out0_src_d   = 1'b1;
      end else if (out0_ready) begin
         out0_valid_d = 1'b0;
      end

      if (g0_to1) begin
         out1_valid_d = 1'b1;
         out1_data_d  = in0_data;
         out1_src_d   = 1'b0;
      end else if (g1_to1) begin
         out1_valid_d = 1'b1;
         out1_data_d  = in1_data;
         out1_src_d   = 1'b1;
      end else if (out1_ready) begin
         out1_valid_d = 1'b0;
      end

      if (grant0 || grant1) begin
         sel_d = g0_to1 || g1_to0;
      end

      // A conflict always targets a free output, so it is always granted
      if (conflict) begin
         rr_d = !rr_q;
         if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out0_valid_q <= 1'b0;
         out0_data_q  <= '0;
         out0_src_q   <= 1'b0;
         out1_valid_q <= 1'b0;
         out1_data_q  <= '0;
         out1_src_q   <= 1'b0;
         sel_q        <= 1'b0;
         cnt_q        <= 8'd0;
         rr_q         <= 1'b0;
      end else begin
         out0_valid_q <= out0_valid_d;
         out0_data_q  <= out0_data_d;
         out0_src_q   <= out0_src_d;
         out1_valid_q <= out1_valid_d;
         out1_data_q  <= out1_data_d;
         out1_src_q   <= out1_src_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         rr_q         <= rr_d;
      end
   end

   assign in0_ready    = grant0;
   assign in1_ready    = grant1;
   assign out0_valid   = out0_valid_q;
   assign out0_data    = out0_data_q;
   assign out0_src     = out0_src_q;
   assign out1_valid   = out1_valid_q;
   assign out1_data    = out1_data_q;
   assign out1_src     = out1_src_q;
   assign sel          = sel_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: doc/xbar2_arbiter.md
XBAR2_ARBITER -- requirements
Module: xbar2_arbiter

Interface
REQ-001 Parameter DW, default 8, sets the data width of every payload port.
REQ-002 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port in0_valid / in1_valid, input, 1 each: requester i has a beat.
REQ-005 Port in0_dest / in1_dest, input, 1 each: target output (0 = out0, 1 = out1).
REQ-006 Port in0_data / in1_data, input, DW each: payload.
REQ-007 Port in0_ready / in1_ready, output, 1 each: beat i accepted this cycle.
REQ-008 Port out0_valid / out1_valid, output, 1 each: registered output beat present.
REQ-009 Port out0_ready / out1_ready, input, 1 each: downstream accepts the beat.
REQ-010 Port out0_data / out1_data, output, DW each: registered payload.
REQ-011 Port out0_src / out1_src, output, 1 each: index of the input that supplied the beat.
REQ-012 Port sel, output, 1: registered crossbar configuration of the last transfer (0 = straight, 1 = swapped).
REQ-013 Port conflict_cnt, output, 8: saturating count of arbitration conflicts.

Function
REQ-014 Output k SHALL be free when !outk_valid or outk_ready.
REQ-015 Input i SHALL request output ini_dest when ini_valid=1.
REQ-016 A requester alone on a free target SHALL be granted in the same cycle.
REQ-017 Two requesters on different free targets SHALL both be granted in the same cycle.
REQ-018 Two requesters on the same free target SHALL form a conflict: only the input named by the internal priority bit rr is granted.
REQ-019 After a granted conflict, rr SHALL point to the losing input; rr SHALL hold in all other cycles.
REQ-020 No grant SHALL be issued to a non-free target; a stalled target SHALL NOT block the other input.
REQ-021 ini_ready SHALL equal grant_i, derived combinationally; it SHALL never be 1 while ini_valid=0.
REQ-022 On grant of i to output d, the next edge SHALL load outd_data=ini_data, outd_src=i and outd_valid=1 (latency 1 cycle).
REQ-023 outk_valid SHALL clear on the edge where outk_ready=1 and no new grant targets k; a simultaneous drain and grant SHALL keep outk_valid=1 with the new beat.
REQ-024 outk_data / outk_src SHALL hold while outk_valid=1 and outk_ready=0.
REQ-025 sel SHALL update on any grant cycle to 1 if a granted in0 targets out1 or a granted in1 targets out0, else 0; with no grant it SHALL hold.
REQ-026 conflict_cnt SHALL increment by 1 on each granted conflict and saturate at 255 without wrapping.
REQ-027 The block SHALL neither drop nor duplicate beats; per-input order SHALL be preserved.

Reset
REQ-028 While rst=1: all outk_valid, outk_data, outk_src, sel, conflict_cnt and rr SHALL be 0, and in0_ready=in1_ready=0.
REQ-029 Assertion of rst mid-transfer SHALL discard held output beats immediately; after release the first grant SHALL use rr=0.

Verification
REQ-030 in0 (dest 0, 0x11) and in1 (dest 1, 0x22), both outputs ready -> both ready=1; next cycle out0=0x11/src0, out1=0x22/src1, sel=0.
REQ-031 in0 (dest 1, 0xA5) alone -> next cycle out1_valid=1, data 0xA5, src 0, sel=1; out0_valid=0.
REQ-032 Both inputs target out0 for 4 cycles, out0_ready=1 -> grants alternate in0,in1,in0,in1; conflict_cnt=4.
REQ-033 out1_ready=0 with out1 full, in1 to out1 and in0 to out0 -> in0 granted, in1_ready=0, out1_data held, conflict_cnt unchanged.
REQ-034 300 consecutive conflicts -> conflict_cnt stays at 255; rst pulsed with out0_valid=1 -> out0_valid=0 immediately, conflict_cnt=0.
